audio_out_gain: RTL and testbench

- Output stage directly downstream of the audio resampler: consumes the mclk-rate signed stereo stream (one sample per clk) and applies a smoothly ramped master gain/mute with saturation and clip indication.
- Drives the core's final audio ports.
- Gain changes and mute ramp one LSB per step tick, so volume changes and power-up never produce pops.

---
 rtl/audio_out_gain.sv | 144 ++++++++++++++
 tb/tb_audio_out_gain.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_gain.sv
// Final audio output stage: ramped master gain/mute on the stereo stream,
// with round-half-up scaling, saturation and held per-channel clip flags.
module audio_out_gain #(
  parameter int IW       = 16,
  parameter int GW       = 8,
  parameter int STEP_DIV = 1008,
  parameter int HOLD_CYC = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [IW-1:0] snd_l_in,
  input  logic [IW-1:0] snd_r_in,
  input  logic [GW-1:0] gain_in,
  input  logic          mute,
  output logic [IW-1:0] snd_l_out,
  output logic [IW-1:0] snd_r_out,
  output logic [GW-1:0] gain_cur,
  output logic          ramping,
  output logic          clip_l,
  output logic          clip_r
);

  localparam int PW = IW + GW + 1;
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = $clog2(HOLD_CYC + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC);
  localparam logic signed [PW:0] RND  = {{(PW-GW+2){1'b0}}, 1'b1, {(GW-2){1'b0}}};
  localparam logic signed [PW:0] MAXV = {{(PW-IW+1){1'b0}}, 1'b0, {(IW-1){1'b1}}};
  localparam logic signed [PW:0] MINV = {{(PW-IW+1){1'b1}}, 1'b1, {(IW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, MUTED} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] step_cnt;
  logic          tick;
  logic [GW-1:0] target;
  logic [GW-1:0] gain_nxt;

  logic signed [IW-1:0] l_p0, r_p0;
  logic signed [PW-1:0] l_p1, r_p1;
  logic signed [PW:0]   l_rnd, r_rnd;
  logic [HW-1:0]        hold_l, hold_r;

  function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW:0] s;
    s = {p[PW-1], p} + RND;
    return s >>> (GW - 1);
  endfunction

  function automatic logic signed [IW-1:0] saturate(input logic signed [PW:0] v);
    if (v > MAXV)      return MAXV[IW-1:0];
    else if (v < MINV) return MINV[IW-1:0];
    else               return v[IW-1:0];
  endfunction

  function automatic logic overflows(input logic signed [PW:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  assign tick    = (step_cnt == CNT_LAST);
  assign ramping = (gain_cur != target);
  assign clip_l  = (hold_l != '0);
  assign clip_r  = (hold_r != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
      target   <= '0;
      gain_cur <= '0;
      state    <= IDLE;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      target   <= mute ? '0 : gain_in;
      gain_cur <= gain_nxt;
      state    <= state_nxt;
    end
  end

  // Direction is recomputed on every tick from any state, so a retarget
  // mid-ramp reverses immediately and the gain never overshoots or wraps.
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain_cur;
    if (tick) begin
      if (gain_cur < target) begin
        gain_nxt  = gain_cur + 1'b1;
        state_nxt = (gain_nxt == target) ? IDLE : RAMP_UP;
      end else if (gain_cur > target) begin
        gain_nxt  = gain_cur - 1'b1;
        if (gain_nxt == target) state_nxt = mute ? MUTED : IDLE;
        else                    state_nxt = RAMP_DOWN;
      end else begin
        state_nxt = (mute && gain_cur == '0) ? MUTED : IDLE;
      end
    end
  end

  // Stage 1: input registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_p0 <= '0;
      r_p0 <= '0;
    end else begin
      l_p0 <= snd_l_in;
      r_p0 <= snd_r_in;
    end
  end

  // Stage 2: multiply by the gain currently applied
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_p1 <= '0;
      r_p1 <= '0;
    end else begin
      l_p1 <= PW'(l_p0) * PW'($signed({1'b0, gain_cur}));
      r_p1 <= PW'(r_p0) * PW'($signed({1'b0, gain_cur}));
    end
  end

  always_comb begin
    l_rnd = round_shift(l_p1);
    r_rnd = round_shift(r_p1);
  end

  // Stage 3: round, saturate, register output; clip hold retriggers on each event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snd_l_out <= '0;
      snd_r_out <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      snd_l_out <= saturate(l_rnd);
      snd_r_out <= saturate(r_rnd);
      if (overflows(l_rnd))   hold_l <= HOLD_LD;
      else if (hold_l != '0)  hold_l <= hold_l - 1'b1;
      if (overflows(r_rnd))   hold_r <= HOLD_LD;
      else if (hold_r != '0)  hold_r <= hold_r - 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_out_gain.sv
// Scoreboard bench for audio_out_gain: directed samples push expected outputs,
// a monitor pops them when the tagged sample emerges three clocks later.
module tb_audio_out_gain;
  localparam int IW = 16;
  localparam int GW = 8;
  localparam int SD = 4;
  localparam int HC = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [IW-1:0] snd_l_in = '0, snd_r_in = '0;
  logic [GW-1:0] gain_in = 8'd128;
  logic          mute = 1'b0;
  logic [IW-1:0] snd_l_out, snd_r_out;
  logic [GW-1:0] gain_cur;
  logic          ramping, clip_l, clip_r;

  typedef struct { int l; int r; int cl; int cr; } exp_t;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk = 1'b0;
  logic [2:0] tag;

  audio_out_gain #(.IW(IW), .GW(GW), .STEP_DIV(SD), .HOLD_CYC(HC)) dut (
    .clk(clk), .reset_n(reset_n), .snd_l_in(snd_l_in), .snd_r_in(snd_r_in),
    .gain_in(gain_in), .mute(mute), .snd_l_out(snd_l_out), .snd_r_out(snd_r_out),
    .gain_cur(gain_cur), .ramping(ramping), .clip_l(clip_l), .clip_r(clip_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) tag <= '0;
    else          tag <= {tag[1:0], chk};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && tag[2]) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got output with no expected entry, required queued entry");
      end else begin
        e = q.pop_front();
        check("out_l", $signed(snd_l_out), e.l);
        check("out_r", $signed(snd_r_out), e.r);
        check("clip_l_sb", clip_l, e.cl);
        check("clip_r_sb", clip_r, e.cr);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input int r, input int el, input int er,
                      input int cl, input int cr);
    exp_t e;
    e.l = el; e.r = er; e.cl = cl; e.cr = cr;
    snd_l_in = IW'(l);
    snd_r_in = IW'(r);
    chk = 1'b1;
    q.push_back(e);
    cyc(1);
    chk = 1'b0;
    snd_l_in = '0;
    snd_r_in = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int  bad_r;
    int  found;
    // Reset state
    #23;
    check("rst_out_l", snd_l_out, 0);
    check("rst_out_r", snd_r_out, 0);
    check("rst_gain", gain_cur, 0);
    check("rst_ramping", ramping, 0);
    check("rst_clip", {clip_l, clip_r}, 0);

    // Power-up fade: 128 steps of 4 clocks
    @(posedge clk); #1;
    reset_n = 1'b1;
    bad_r = 0;
    for (int k = 1; k <= 511; k++) begin
      cyc(1);
      if (ramping !== 1'b1) bad_r = 1;
      if (k == 256) check("fade_mid_gain", gain_cur, 64);
    end
    check("fade_ramping_high", bad_r, 0);
    check("fade_gain_511", gain_cur, 127);
    cyc(1);
    check("fade_gain_512", gain_cur, 128);
    check("fade_ramping_done", ramping, 0);
    send(1000, -1000, 1000, -1000, 0, 0);
    send(32767, -32768, 32767, -32768, 0, 0);
    cyc(5);

    // Rounding at gain 64
    gain_in = 8'd64;
    cyc(270);
    check("gain_64", gain_cur, 64);
    send(1001, -1001, 501, -500, 0, 0);
    send(1, -1, 1, 0, 0, 0);
    send(-1, 1, 0, 1, 0, 0);
    cyc(5);

    // Saturation at gain 255 with clip hold retrigger
    gain_in = 8'd255;
    cyc(780);
    check("gain_255", gain_cur, 255);
    check("clip_before", {clip_l, clip_r}, 0);
    send(20000, -20000, 32767, -32768, 1, 1);
    cyc(31);
    send(20000, -20000, 32767, -32768, 1, 1);
    cyc(34);
    check("clip_l_extended", clip_l, 1);
    check("clip_r_extended", clip_r, 1);
    cyc(31);
    check("clip_l_last", clip_l, 1);
    check("clip_r_last", clip_r, 1);
    cyc(1);
    check("clip_l_drop", clip_l, 0);
    check("clip_r_drop", clip_r, 0);
    send(100, -100, 199, -199, 0, 0);
    cyc(5);

    // Mute ramp down and back up
    gain_in = 8'd128;
    cyc(520);
    check("gain_128_again", gain_cur, 128);
    mute = 1'b1;
    cyc(260);
    check("mute_ramping", ramping, 1);
    cyc(260);
    check("mute_gain", gain_cur, 0);
    check("mute_ramping_done", ramping, 0);
    send(12345, -12345, 0, 0, 0, 0);
    cyc(5);
    mute = 1'b0;
    cyc(520);
    check("unmute_gain", gain_cur, 128);
    send(1000, -1000, 1000, -1000, 0, 0);
    cyc(5);

    // Mid-ramp retarget at gain_cur=50
    gain_in = 8'd0;
    cyc(520);
    check("retarget_start", gain_cur, 0);
    gain_in = 8'd200;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (gain_cur == 8'd50) begin
        found = 1;
        break;
      end
    end
    check("reach_50", found, 1);
    gain_in = 8'd30;
    cyc(3);
    check("hold_50", gain_cur, 50);
    cyc(1);
    check("reverse_49", gain_cur, 49);
    check("reverse_ramping", ramping, 1);
    cyc(75);
    check("retarget_31", gain_cur, 31);
    cyc(1);
    check("retarget_30", gain_cur, 30);
    check("retarget_idle", ramping, 0);
    cyc(20);
    check("retarget_stay", gain_cur, 30);

    // Async reset during ramp and clip hold
    gain_in = 8'd255;
    cyc(920);
    send(20000, -20000, 32767, -32768, 1, 1);
    cyc(4);
    gain_in = 8'd100;
    snd_l_in = 16'sd20000;
    snd_r_in = -16'sd20000;
    cyc(10);
    check("pre_rst_ramping", ramping, 1);
    check("pre_rst_clip_l", clip_l, 1);
    check("pre_rst_out_l", $signed(snd_l_out), 32767);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_l", snd_l_out, 0);
    check("arst_out_r", snd_r_out, 0);
    check("arst_gain", gain_cur, 0);
    check("arst_clip_l", clip_l, 0);
    check("arst_clip_r", clip_r, 0);
    check("arst_ramping", ramping, 0);
    snd_l_in = '0;
    snd_r_in = '0;
    gain_in = 8'd128;
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
    check("refade_0", gain_cur, 0);
    cyc(1);
    check("refade_1", gain_cur, 1);
    check("refade_ramping", ramping, 1);
    cyc(508);
    check("refade_128", gain_cur, 128);
    send(1000, -1000, 1000, -1000, 0, 0);
    cyc(5);
    check("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
